mem_arbiter: RTL and testbench

- Shares one single-ported, variable-latency memory bus between the pipeline's instruction-fetch port and its data (MEM-stage) port.
- Sits between the cpu top level and external memory, replacing the separate ROM and RAM ports.
- Sequences bus transactions and raises per-port stall requests to ctrl, freezing the pipeline until every active request this cycle is served.
- Data port has fixed priority over fetch.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data port and memory bus signals of mem_arbiter
// slave is the arbiter side; master is the cpu + memory environment side.
interface mem_arbiter_if;
  logic        if_re;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stallreq;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stallreq;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport slave (
    input  if_re, if_addr, mem_re, mem_we, mem_addr, mem_sel, mem_wdata,
    input  bus_rdata, bus_ack,
    output if_rdata, if_stallreq, mem_rdata, mem_stallreq,
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err
  );

  modport master (
    output if_re, if_addr, mem_re, mem_we, mem_addr, mem_sel, mem_wdata,
    output bus_rdata, bus_ack,
    input  if_rdata, if_stallreq, mem_rdata, mem_stallreq,
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory bus between fetch and data ports, data first
// Optional one-entry fetch buffer enabled by FETCH_BUF_EN.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave arb
);

  typedef enum logic [1:0] {IDLE, DATA_BUS, FETCH_BUS, RELEASE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        data_done_q, data_done_d;
  logic        fetch_done_q, fetch_done_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        bus_err_q, bus_err_d;

  logic        data_req;
  logic        fetch_pend;
  logic        bus_done;
  logic        timed_out;
  logic [31:0] done_rdata;
  logic        buf_hit;
  logic [31:0] buf_rdata;

  assign data_req   = arb.mem_re | arb.mem_we;
  assign fetch_pend = arb.if_re & ~fetch_done_q;
  // Ack takes precedence over a timeout landing in the same cycle.
  assign bus_done   = bus_req_q & (arb.bus_ack | (cnt_q == TO_LAST));
  assign timed_out  = bus_req_q & ~arb.bus_ack & (cnt_q == TO_LAST);
  assign done_rdata = arb.bus_ack ? arb.bus_rdata : 32'h0;

`ifdef FETCH_BUF_EN
  logic        buf_valid_q;
  logic [29:0] buf_tag_q;
  logic [31:0] buf_data_q;

  assign buf_hit   = buf_valid_q & arb.if_re & (arb.if_addr[31:2] == buf_tag_q);
  assign buf_rdata = buf_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else if (state_q == FETCH_BUS && bus_req_q && arb.bus_ack) begin
      buf_valid_q <= 1'b1;
      buf_tag_q   <= bus_addr_q[31:2];
      buf_data_q  <= arb.bus_rdata;
    end else if (state_q == IDLE && arb.mem_we && arb.mem_addr[31:2] == buf_tag_q) begin
      buf_valid_q <= 1'b0;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = 32'h0;
`endif

  always_comb begin
    state_d      = state_q;
    data_done_d  = data_done_q;
    fetch_done_d = fetch_done_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_sel_d    = bus_sel_q;
    bus_wdata_d  = bus_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    bus_err_d    = bus_err_q | timed_out;

    case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d     = DATA_BUS;
          bus_req_d   = 1'b1;
          bus_we_d    = arb.mem_we;
          bus_addr_d  = arb.mem_addr;
          bus_sel_d   = arb.mem_we ? arb.mem_sel : 4'hF;
          bus_wdata_d = arb.mem_we ? arb.mem_wdata : 32'h0;
          cnt_d       = '0;
          if (buf_hit) begin
            fetch_done_d = 1'b1;
            if_rdata_d   = buf_rdata;
          end
        end else if (arb.if_re) begin
          if (buf_hit) begin
            fetch_done_d = 1'b1;
            if_rdata_d   = buf_rdata;
            state_d      = RELEASE;
          end else begin
            state_d     = FETCH_BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b0;
            bus_addr_d  = arb.if_addr;
            bus_sel_d   = 4'hF;
            bus_wdata_d = 32'h0;
            cnt_d       = '0;
          end
        end
      end

      DATA_BUS: begin
        if (bus_done) begin
          bus_req_d   = 1'b0;
          data_done_d = 1'b1;
          if (!bus_we_q) mem_rdata_d = done_rdata;
          if (fetch_pend && buf_hit) begin
            fetch_done_d = 1'b1;
            if_rdata_d   = buf_rdata;
            state_d      = RELEASE;
          end else if (fetch_pend) begin
            state_d = FETCH_BUS;
          end else begin
            state_d = RELEASE;
          end
        end else if (bus_req_q) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      FETCH_BUS: begin
        // Entered from DATA_BUS with bus_req low: issue after one idle bus cycle.
        if (!bus_req_q) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = arb.if_addr;
          bus_sel_d   = 4'hF;
          bus_wdata_d = 32'h0;
          cnt_d       = '0;
        end else if (bus_done) begin
          bus_req_d    = 1'b0;
          fetch_done_d = 1'b1;
          if_rdata_d   = done_rdata;
          state_d      = RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RELEASE: begin
        data_done_d  = 1'b0;
        fetch_done_d = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      data_done_q  <= 1'b0;
      fetch_done_q <= 1'b0;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_sel_q    <= '0;
      bus_wdata_q  <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_done_q  <= data_done_d;
      fetch_done_q <= fetch_done_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_sel_q    <= bus_sel_d;
      bus_wdata_q  <= bus_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Stalls are gated by rst so every output reads 0 while reset is held.
  assign arb.mem_stallreq = data_req & ~data_done_q & (state_q != RELEASE) & ~rst;
  assign arb.if_stallreq  = arb.if_re & ~fetch_done_q & (state_q != RELEASE) & ~rst;

  assign arb.if_rdata  = if_rdata_q;
  assign arb.mem_rdata = mem_rdata_q;
  assign arb.bus_req   = bus_req_q;
  assign arb.bus_we    = bus_we_q;
  assign arb.bus_addr  = bus_addr_q;
  assign arb.bus_sel   = bus_sel_q;
  assign arb.bus_wdata = bus_wdata_q;
  assign arb.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a variable-latency memory
// Expected bus transactions and release-cycle results are queued by stimulus, checked by a monitor.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  mem_arbiter_if bi ();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bi)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          dur;
  } bus_t;

  typedef struct {
    logic        chk_if;
    logic [31:0] ird;
    logic        chk_mem;
    logic [31:0] mrd;
    logic        err;
    int          stalls;
  } rel_t;

  bus_t bq[$];
  rel_t rq[$];
  bus_t cur;
  int   checks = 0;
  int   failures = 0;
  int   dur_cnt = 0;
  int   stall_cnt = 0;
  int   mem_lat = 1;
  int   mcnt = 0;
  logic prev_req = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h100) ? 32'h24010005 : {a[15:0], 16'hC0DE};
  endfunction

  // Memory: acks on the mem_lat-th cycle of bus_req; mem_lat==0 never acks.
  always @(negedge clk) begin
    if (bi.bus_req === 1'b1) begin
      if (mem_lat != 0 && mcnt == mem_lat - 1) begin
        bi.bus_ack   = 1'b1;
        bi.bus_rdata = memval(bi.bus_addr);
        mcnt         = 0;
      end else begin
        bi.bus_ack   = 1'b0;
        bi.bus_rdata = 32'h0;
        mcnt++;
      end
    end else begin
      bi.bus_ack   = 1'b0;
      bi.bus_rdata = 32'h0;
      mcnt         = 0;
    end
  end

  always @(negedge clk) begin
    rel_t r;
    if (rst) begin
      prev_req  = 1'b0;
      stall_cnt = 0;
    end else begin
      if (bi.bus_req) begin
        if (!prev_req) begin
          if (bq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bus_unexpected actual_addr=%h required=no_transaction", bi.bus_addr);
            cur = '{we: bi.bus_we, addr: bi.bus_addr, sel: bi.bus_sel, wdata: bi.bus_wdata, dur: 0};
          end else begin
            cur = bq.pop_front();
            chk("bus_we", bi.bus_we, cur.we);
            chk("bus_addr", bi.bus_addr, cur.addr);
            chk("bus_sel", bi.bus_sel, cur.sel);
            chk("bus_wdata", bi.bus_wdata, cur.wdata);
          end
          dur_cnt = 1;
        end else begin
          dur_cnt++;
          chk("bus_hold_addr", bi.bus_addr, cur.addr);
          chk("bus_hold_wdata", bi.bus_wdata, cur.wdata);
          chk("bus_hold_sel", bi.bus_sel, cur.sel);
        end
      end else if (prev_req && cur.dur != 0) begin
        chk("bus_len", dur_cnt, cur.dur);
      end
      prev_req = bi.bus_req;

      if ((bi.if_re | bi.mem_re | bi.mem_we) && !bi.if_stallreq && !bi.mem_stallreq) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL release_unexpected actual=release required=stall");
        end else begin
          r = rq.pop_front();
          if (r.chk_if) chk("if_rdata", bi.if_rdata, r.ird);
          if (r.chk_mem) chk("mem_rdata", bi.mem_rdata, r.mrd);
          chk("bus_err", bi.bus_err, r.err);
          chk("stall_cycles", stall_cnt, r.stalls);
        end
        stall_cnt = 0;
      end else if (bi.if_stallreq | bi.mem_stallreq) begin
        stall_cnt++;
      end
    end
  end

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] w, input int d);
    bus_t b;
    b = '{we: we, addr: a, sel: s, wdata: w, dur: d};
    bq.push_back(b);
  endtask

  task automatic exp_rel(input logic ci, input logic [31:0] ird, input logic cm,
                         input logic [31:0] mrd, input logic err, input int st);
    rel_t r;
    r = '{chk_if: ci, ird: ird, chk_mem: cm, mrd: mrd, err: err, stalls: st};
    rq.push_back(r);
  endtask

  task automatic drop_inputs();
    bi.if_re     = 1'b0;
    bi.mem_re    = 1'b0;
    bi.mem_we    = 1'b0;
    bi.if_addr   = 32'h0;
    bi.mem_addr  = 32'h0;
    bi.mem_sel   = 4'h0;
    bi.mem_wdata = 32'h0;
  endtask

  task automatic issue(input logic ire, input logic [31:0] ia, input logic mre, input logic mwe,
                       input logic [31:0] ma, input logic [3:0] ms, input logic [31:0] mw,
                       input int lat);
    logic ok;
    @(posedge clk);
    #1;
    mem_lat      = lat;
    bi.if_re     = ire;
    bi.if_addr   = ia;
    bi.mem_re    = mre;
    bi.mem_we    = mwe;
    bi.mem_addr  = ma;
    bi.mem_sel   = ms;
    bi.mem_wdata = mw;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (!bi.if_stallreq && !bi.mem_stallreq) ok = 1'b1;
    end
    chk("release_wait", ok, 1'b1);
    @(posedge clk);
    #1;
    drop_inputs();
  endtask

  initial begin
    rst = 1'b1;
    drop_inputs();
    bi.bus_ack   = 1'b0;
    bi.bus_rdata = 32'h0;
    bi.if_re     = 1'b1;
    bi.mem_re    = 1'b1;
    #12;
    chk("rst_bus_req", bi.bus_req, 1'b0);
    chk("rst_if_stall", bi.if_stallreq, 1'b0);
    chk("rst_mem_stall", bi.mem_stallreq, 1'b0);
    chk("rst_bus_err", bi.bus_err, 1'b0);
    chk("rst_if_rdata", bi.if_rdata, 32'h0);
    chk("rst_bus_addr", bi.bus_addr, 32'h0);
    drop_inputs();
    @(negedge clk);
    rst = 1'b0;

    // fetch only, latency 3
    exp_bus(1'b0, 32'h100, 4'hF, 32'h0, 3);
    exp_rel(1'b1, 32'h24010005, 1'b0, 32'h0, 1'b0, 4);
    issue(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 3);

    // simultaneous read + fetch: data first, one idle bus cycle, then fetch
    exp_bus(1'b0, 32'h200, 4'hF, 32'h0, 2);
    exp_bus(1'b0, 32'h104, 4'hF, 32'h0, 2);
    exp_rel(1'b1, 32'h0104C0DE, 1'b1, 32'h0200C0DE, 1'b0, 6);
    issue(1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0, 2);

    // write leaves mem_rdata unchanged
    exp_bus(1'b1, 32'h300, 4'h3, 32'hDEADBEEF, 2);
    exp_rel(1'b0, 32'h0, 1'b1, 32'h0200C0DE, 1'b0, 3);
    issue(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 4'h3, 32'hDEADBEEF, 2);

    // re and we together act as a write
    exp_bus(1'b1, 32'h304, 4'hC, 32'hCAFEF00D, 1);
    exp_rel(1'b0, 32'h0, 1'b1, 32'h0200C0DE, 1'b0, 2);
    issue(1'b0, 32'h0, 1'b1, 1'b1, 32'h304, 4'hC, 32'hCAFEF00D, 1);

    // ack on the same cycle the timeout would fire: ack wins
    exp_bus(1'b0, 32'h108, 4'hF, 32'h0, 4);
    exp_rel(1'b1, 32'h0108C0DE, 1'b0, 32'h0, 1'b0, 5);
    issue(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4);

    // repeated fetch, write to the same word, fetch again
    exp_bus(1'b0, 32'h10C, 4'hF, 32'h0, 2);
    exp_rel(1'b1, 32'h010CC0DE, 1'b0, 32'h0, 1'b0, 3);
    issue(1'b1, 32'h10C, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2);
`ifdef FETCH_BUF_EN
    exp_rel(1'b1, 32'h010CC0DE, 1'b0, 32'h0, 1'b0, 1);
`else
    exp_bus(1'b0, 32'h10C, 4'hF, 32'h0, 2);
    exp_rel(1'b1, 32'h010CC0DE, 1'b0, 32'h0, 1'b0, 3);
`endif
    issue(1'b1, 32'h10C, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2);
    exp_bus(1'b1, 32'h10C, 4'hF, 32'h12345678, 1);
    exp_rel(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2);
    issue(1'b0, 32'h0, 1'b0, 1'b1, 32'h10C, 4'hF, 32'h12345678, 1);
    exp_bus(1'b0, 32'h10C, 4'hF, 32'h0, 2);
    exp_rel(1'b1, 32'h010CC0DE, 1'b0, 32'h0, 1'b0, 3);
    issue(1'b1, 32'h10C, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 2);

    // memory never acks: 4-cycle timeout, rdata 0, sticky error
    exp_bus(1'b0, 32'h400, 4'hF, 32'h0, 4);
    exp_rel(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 5);
    issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 4'h0, 32'h0, 0);

    exp_bus(1'b0, 32'h104, 4'hF, 32'h0, 1);
    exp_rel(1'b1, 32'h0104C0DE, 1'b0, 32'h0, 1'b1, 2);
    issue(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1);

    exp_bus(1'b0, 32'h208, 4'hF, 32'h0, 1);
    exp_rel(1'b0, 32'h0, 1'b1, 32'h0208C0DE, 1'b1, 2);
    issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h208, 4'h0, 32'h0, 1);

    // async reset in the middle of a data transaction
    @(posedge clk);
    #1;
    mem_lat     = 0;
    bi.mem_re   = 1'b1;
    bi.mem_addr = 32'h500;
    @(posedge clk);
    #1;
    chk("mid_bus_req", bi.bus_req, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_bus_req", bi.bus_req, 1'b0);
    chk("arst_mem_stall", bi.mem_stallreq, 1'b0);
    chk("arst_if_rdata", bi.if_rdata, 32'h0);
    chk("arst_mem_rdata", bi.mem_rdata, 32'h0);
    chk("arst_bus_err", bi.bus_err, 1'b0);
    drop_inputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", bi.bus_req, 1'b0);
    end

    repeat (3) @(posedge clk);
    chk("bus_q_empty", bq.size(), 0);
    chk("rel_q_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
